fsm_multi_timed: RTL and testbench



---
 rtl/fsm_multi_timed.sv | 115 +++++++++++
 tb/tb_fsm_multi_timed.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fsm_multi_timed.sv
// fsm_multi_timed: N_CH independent three-state a/b control FSMs sharing a
// global enable. Each channel has a dwell counter that forces it back to S0
// (with a one-cycle timeout pulse) after TIMEOUT enabled cycles in S1/S2.
// st, timeout are registered; dout and any_s2 are pure decodes of st.
module fsm_multi_timed #(
    parameter int N_CH    = 2,
    parameter int TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [N_CH-1:0]       a,
    input  logic [N_CH-1:0]       b,
    output logic [2*N_CH-1:0]     st,
    output logic [3*N_CH-1:0]     dout,
    output logic [N_CH-1:0]       timeout,
    output logic                  any_s2
);

    // Counter only needs to reach TIMEOUT-1; keep at least one bit so the
    // TIMEOUT=0 build still elaborates.
    localparam int CNT_W_RAW = $clog2(TIMEOUT + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3   // unreachable; behaves like S2
    } state_t;

    logic [N_CH-1:0] is_s2;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            state_t           st_reg, st_next, ab_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             to_reg, to_next;
            logic [2:0]       dec;

            // Input-driven transition table; "stay" is ab_next == st_reg.
            always_comb begin
                ab_next = st_reg;
                case (st_reg)
                    S0: begin
                        if (a[gi] && b[gi])       ab_next = S2;
                        else if (b[gi])           ab_next = S1;
                    end
                    S1: begin
                        if (a[gi] && b[gi])       ab_next = S2;
                        else if (a[gi])           ab_next = S0;
                    end
                    default: begin
                        if (a[gi] && !b[gi])      ab_next = S0;
                        else if (!a[gi] && b[gi]) ab_next = S1;
                    end
                endcase
            end

            // Combine input transitions with dwell counting and timeout;
            // an input transition always beats a pending timeout.
            always_comb begin
                st_next  = st_reg;
                cnt_next = cnt_reg;
                to_next  = 1'b0;
                if (en) begin
                    if (ab_next != st_reg) begin
                        st_next  = ab_next;
                        cnt_next = '0;
                    end else if (st_reg == S0) begin
                        cnt_next = '0;
                    end else if (TIMEOUT > 0 && cnt_reg == CNT_LAST) begin
                        st_next  = S0;
                        cnt_next = '0;
                        to_next  = 1'b1;
                    end else if (TIMEOUT > 0) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            // State, dwell counter and timeout pulse registers.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    st_reg  <= S0;
                    cnt_reg <= '0;
                    to_reg  <= 1'b0;
                end else begin
                    st_reg  <= st_next;
                    cnt_reg <= cnt_next;
                    to_reg  <= to_next;
                end
            end

            // Output decode of the current state.
            always_comb begin
                case (st_reg)
                    S0:      dec = 3'b001;
                    S1:      dec = 3'b010;
                    default: dec = 3'b011;
                endcase
            end

            assign st[2*gi +: 2]   = st_reg;
            assign dout[3*gi +: 3] = dec;
            assign timeout[gi]     = to_reg;
            assign is_s2[gi]       = (st_reg == S2);
        end
    endgenerate

    assign any_s2 = |is_s2;

endmodule

// File: tb/tb_fsm_multi_timed.sv
// Directed bench for fsm_multi_timed (N_CH=2, TIMEOUT=4) plus a TIMEOUT=0
// instance. Expected results are queued when a step is driven and compared
// after the following rising edge.
module tb_fsm_multi_timed;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] a, b;
    logic [3:0] st;
    logic [5:0] dout;
    logic [1:0] timeout;
    logic       any_s2;

    logic       en2;
    logic [1:0] a2, b2;
    logic [3:0] st2;
    logic [5:0] dout2;
    logic [1:0] to2;
    logic       any2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] st;
        logic [1:0] to;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fsm_multi_timed #(.N_CH(2), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
        .st(st), .dout(dout), .timeout(timeout), .any_s2(any_s2)
    );

    fsm_multi_timed #(.N_CH(2), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en2), .a(a2), .b(b2),
        .st(st2), .dout(dout2), .timeout(to2), .any_s2(any2)
    );

    function automatic logic [2:0] dec(input logic [1:0] s);
        case (s)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            default: return 3'b011;
        endcase
    endfunction

    function automatic logic [5:0] dec2(input logic [3:0] s);
        return {dec(s[3:2]), dec(s[1:0])};
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input string tag, input logic r, input logic e,
                        input logic [1:0] av, input logic [1:0] bv,
                        input logic [3:0] est, input logic [1:0] eto);
        exp_t x;
        rst_n = r; en = e; a = av; b = bv;
        x.st = est; x.to = eto;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        checks++;
        assert (st === x.st) else begin
            failures++;
            $error("FAIL %s st: observed=%b expected=%b", tag, st, x.st);
        end
        checks++;
        assert (dout === dec2(x.st)) else begin
            failures++;
            $error("FAIL %s dout: observed=%b expected=%b", tag, dout, dec2(x.st));
        end
        checks++;
        assert (timeout === x.to) else begin
            failures++;
            $error("FAIL %s timeout: observed=%b expected=%b", tag, timeout, x.to);
        end
        checks++;
        assert (any_s2 === (x.st[3:2] == 2'd2 || x.st[1:0] == 2'd2)) else begin
            failures++;
            $error("FAIL %s any_s2: observed=%b for st=%b", tag, any_s2, x.st);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; a = 2'b00; b = 2'b00;
        en2 = 1'b1; a2 = 2'b00; b2 = 2'b00;
        @(posedge clk); #1;

        // 1. Reset dominates a=b=11, then release
        step("rst0", 0, 1, 2'b11, 2'b11, 4'b0000, 2'b00);
        step("rst1", 0, 1, 2'b11, 2'b11, 4'b0000, 2'b00);
        step("rel",  1, 1, 2'b11, 2'b11, 4'b1010, 2'b00);
        step("clr",  0, 1, 2'b00, 2'b00, 4'b0000, 2'b00);

        // 2. Transition table on channel 0, channel 1 idle
        step("s0_s1", 1, 1, 2'b00, 2'b01, 4'b0001, 2'b00);
        step("s1_s2", 1, 1, 2'b01, 2'b01, 4'b0010, 2'b00);
        step("s2_s1", 1, 1, 2'b00, 2'b01, 4'b0001, 2'b00);
        step("s1_s0", 1, 1, 2'b01, 2'b00, 4'b0000, 2'b00);
        step("s0_s2", 1, 1, 2'b01, 2'b01, 4'b0010, 2'b00);
        step("s2_s0", 1, 1, 2'b01, 2'b00, 4'b0000, 2'b00);

        // 3. Timeout from S1 then from S2
        step("to1_in", 1, 1, 2'b00, 2'b01, 4'b0001, 2'b00);
        for (int i = 0; i < 3; i++) step("to1_dw", 1, 1, 2'b00, 2'b00, 4'b0001, 2'b00);
        step("to1_fire", 1, 1, 2'b00, 2'b00, 4'b0000, 2'b01);
        step("to1_end",  1, 1, 2'b00, 2'b00, 4'b0000, 2'b00);
        step("to2_in", 1, 1, 2'b01, 2'b01, 4'b0010, 2'b00);
        for (int i = 0; i < 3; i++) step("to2_dw", 1, 1, 2'b00, 2'b00, 4'b0010, 2'b00);
        step("to2_fire", 1, 1, 2'b00, 2'b00, 4'b0000, 2'b01);
        step("to2_end",  1, 1, 2'b00, 2'b00, 4'b0000, 2'b00);

        // 4a. Input transition at count 3 beats timeout and restarts dwell
        step("pr_in", 1, 1, 2'b00, 2'b01, 4'b0001, 2'b00);
        for (int i = 0; i < 3; i++) step("pr_dw", 1, 1, 2'b00, 2'b00, 4'b0001, 2'b00);
        step("pr_win", 1, 1, 2'b01, 2'b01, 4'b0010, 2'b00);
        for (int i = 0; i < 3; i++) step("pr_dw2", 1, 1, 2'b00, 2'b00, 4'b0010, 2'b00);
        step("pr_fire", 1, 1, 2'b00, 2'b00, 4'b0000, 2'b01);
        step("pr_end",  1, 1, 2'b00, 2'b00, 4'b0000, 2'b00);

        // 4b. Bounce S1<->S2 every 3 cycles: no timeout
        step("bn_in", 1, 1, 2'b00, 2'b01, 4'b0001, 2'b00);
        for (int k = 0; k < 3; k++) begin
            step("bn_s1", 1, 1, 2'b00, 2'b00, 4'b0001, 2'b00);
            step("bn_s1", 1, 1, 2'b00, 2'b00, 4'b0001, 2'b00);
            step("bn_up", 1, 1, 2'b01, 2'b01, 4'b0010, 2'b00);
            step("bn_s2", 1, 1, 2'b00, 2'b00, 4'b0010, 2'b00);
            step("bn_s2", 1, 1, 2'b00, 2'b00, 4'b0010, 2'b00);
            step("bn_dn", 1, 1, 2'b00, 2'b01, 4'b0001, 2'b00);
        end
        step("bn_out", 1, 1, 2'b01, 2'b00, 4'b0000, 2'b00);

        // 5. Enable freeze at count 2, inputs ignored while disabled
        step("fz_in", 1, 1, 2'b00, 2'b01, 4'b0001, 2'b00);
        for (int i = 0; i < 2; i++) step("fz_dw", 1, 1, 2'b00, 2'b00, 4'b0001, 2'b00);
        for (int i = 0; i < 10; i++) step("fz_hold", 1, 0, 2'b01, 2'b00, 4'b0001, 2'b00);
        step("fz_dw3", 1, 1, 2'b00, 2'b00, 4'b0001, 2'b00);
        step("fz_fire", 1, 1, 2'b00, 2'b00, 4'b0000, 2'b01);
        step("fz_end",  1, 1, 2'b00, 2'b00, 4'b0000, 2'b00);

        // Channel independence: ch0 in S1 and ch1 in S2 time out together
        step("ind_in", 1, 1, 2'b10, 2'b11, 4'b1001, 2'b00);
        for (int i = 0; i < 3; i++) step("ind_dw", 1, 1, 2'b00, 2'b00, 4'b1001, 2'b00);
        step("ind_fire", 1, 1, 2'b00, 2'b00, 4'b0000, 2'b11);
        step("ind_end",  1, 1, 2'b00, 2'b00, 4'b0000, 2'b00);

        // 6a. Reset at count 3 cancels the pending timeout
        step("mr_in", 1, 1, 2'b00, 2'b01, 4'b0001, 2'b00);
        for (int i = 0; i < 3; i++) step("mr_dw", 1, 1, 2'b00, 2'b00, 4'b0001, 2'b00);
        step("mr_rst", 0, 1, 2'b00, 2'b00, 4'b0000, 2'b00);
        for (int i = 0; i < 5; i++) step("mr_after", 1, 1, 2'b00, 2'b00, 4'b0000, 2'b00);

        // 6b. TIMEOUT=0 instance held in S1 for 1000 cycles
        a2 = 2'b00; b2 = 2'b01;
        @(posedge clk); #1;
        checks++;
        assert (st2 === 4'b0001) else begin
            failures++;
            $error("FAIL nt_in st: observed=%b expected=%b", st2, 4'b0001);
        end
        b2 = 2'b00;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            checks++;
            assert (st2 === 4'b0001 && to2 === 2'b00 && dout2 === 6'b001010 && any2 === 1'b0) else begin
                failures++;
                $error("FAIL nt_hold cyc %0d: observed st=%b to=%b dout=%b any=%b expected st=0001 to=00 dout=001010 any=0",
                       i, st2, to2, dout2, any2);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
